// File: rtl/mem_bus_master.sv
// Byte-wide bus initiator: serialises instruction fetches and load/store accesses
// into 8-bit transactions, handling read latency, bus pauses and IO backpressure.
module mem_bus_master #(
  parameter int unsigned IO_SEL_HI = 17,
  parameter int unsigned IO_SEL_LO = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic        busy
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       addr, wdata, rbuf, buf_cap, ext, wsh;
  logic [IDX_W-1:0]  cnt, iss, rcv;
  logic [1:0]        size;
  logic              sgn, is_ls, p0, p1;
  logic              io, issue_rd, last_cap, wr_go;

  logic [31:0]       mem_a_d, if_data_d, ls_rdata_d;
  logic [7:0]        mem_dout_d;
  logic              mem_wr_d, if_done_d, ls_done_d, busy_d;

  // p0: an issue is on the bus this cycle; p1: its data is on mem_din this cycle
  assign io       = (addr[IO_SEL_HI:IO_SEL_LO] == 2'b11);
  assign issue_rd = (iss < cnt) && (!io || !p0);
  assign last_cap = p1 && ((rcv + 3'd1) == cnt);
  assign wr_go    = (iss < cnt) && !(io && io_buffer_full);
  assign wsh      = wdata >> {iss[1:0], 3'b000};

  // Merge the arriving byte and apply load extension
  always_comb begin
    buf_cap = rbuf;
    buf_cap[{rcv[1:0], 3'b000} +: 8] = mem_din;
    case (size)
      2'b00:   ext = {{24{sgn & buf_cap[7]}}, buf_cap[7:0]};
      2'b01:   ext = {{16{sgn & buf_cap[15]}}, buf_cap[15:0]};
      default: ext = buf_cap;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // DONE always lasts one cycle so the done pulse stays single even if the bus pauses
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rdy_in && (ls_req || if_req))
                 state_nxt = (ls_req && ls_we) ? WRITE : READ;
      READ:    if (rdy_in && last_cap) state_nxt = DONE;
      WRITE:   if (rdy_in && (iss == cnt)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_a_d    = '0;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data;
    ls_rdata_d = ls_rdata;
    busy_d     = (state_nxt != IDLE);
    if (!rdy_in && (state == READ || state == WRITE)) begin
      mem_a_d = mem_a;
    end else if (rdy_in) begin
      case (state)
        READ: begin
          if (issue_rd) mem_a_d = addr + 32'(iss);
          if (last_cap) begin
            if (is_ls) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = ext;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_cap;
            end
          end
        end
        WRITE: begin
          if (wr_go) begin
            mem_a_d    = addr + 32'(iss);
            mem_wr_d   = 1'b1;
            mem_dout_d = wsh[7:0];
          end else if (iss == cnt) begin
            ls_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      mem_a    <= mem_a_d;
      mem_wr   <= mem_wr_d;
      mem_dout <= mem_dout_d;
      if_done  <= if_done_d;
      ls_done  <= ls_done_d;
      if_data  <= if_data_d;
      ls_rdata <= ls_rdata_d;
      busy     <= busy_d;
    end
  end

  // Request latch and byte pointers; a pause rewinds reads to the first uncaptured byte
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr  <= '0;
      wdata <= '0;
      rbuf  <= '0;
      cnt   <= '0;
      iss   <= '0;
      rcv   <= '0;
      size  <= '0;
      sgn   <= 1'b0;
      is_ls <= 1'b0;
      p0    <= 1'b0;
      p1    <= 1'b0;
    end else if (!rdy_in) begin
      p0 <= 1'b0;
      p1 <= 1'b0;
      if (state == READ) iss <= rcv;
    end else begin
      case (state)
        IDLE: if (ls_req || if_req) begin
          iss  <= '0;
          rcv  <= '0;
          p0   <= 1'b0;
          p1   <= 1'b0;
          rbuf <= '0;
          if (ls_req) begin
            addr  <= ls_addr;
            wdata <= ls_wdata;
            size  <= ls_size;
            sgn   <= ls_signed;
            is_ls <= 1'b1;
            case (ls_size)
              2'b00:   cnt <= 3'd1;
              2'b01:   cnt <= 3'd2;
              default: cnt <= 3'd4;
            endcase
          end else begin
            addr  <= if_addr;
            size  <= 2'b10;
            sgn   <= 1'b0;
            is_ls <= 1'b0;
            cnt   <= 3'd4;
          end
        end
        READ: begin
          if (p1) begin
            rbuf <= buf_cap;
            rcv  <= rcv + 3'd1;
          end
          if (issue_rd) iss <= iss + 3'd1;
          p1 <= p0;
          p0 <= issue_rd;
        end
        WRITE: if (wr_go) iss <= iss + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a 256-byte bus memory model that
// samples mem_a each unpaused edge and returns the byte one cycle later.
module tb_mem_bus_master;

  logic        clk_in, rst_in, rdy_in;
  logic        if_req, if_done, ls_req, ls_we, ls_signed, ls_done;
  logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
  logic [1:0]  ls_size;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr, io_buffer_full, busy;

  logic [7:0]  ram [0:255];
  logic        pl_en;
  logic [7:0]  pl_a, pl_d;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  mem_bus_master dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .busy(busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Bus memory: only unpaused edges write or read
  always @(posedge clk_in) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (rdy_in && mem_wr) begin
      ram[mem_a[7:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    if (rdy_in) mem_din <= ram[mem_a[7:0]];
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      pl_en = 1'b1;
      pl_a  = a + 8'(i);
      pl_d  = w[8*i +: 8];
    end
    @(negedge clk_in);
    pl_en = 1'b0;
  endtask

  // Issues one load/store; lat is the cycle of ls_done after the accepting edge, -1 on timeout
  task automatic run_ls(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    @(negedge clk_in);
    ls_we = we; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    lat = -1;
    rd  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (ls_done) begin
        lat = c;
        rd  = ls_rdata;
        break;
      end
    end
    ls_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    total++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: mem_a=%h mem_wr=%b mem_dout=%h busy=%b want all 0", mem_a, mem_wr, mem_dout, busy);
    end
    total++;
    if (if_done !== 1'b0 || ls_done !== 1'b0 || if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: if_done=%b ls_done=%b if_data=%h ls_rdata=%h want all 0", if_done, ls_done, if_data, ls_rdata);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] a_seq [0:6];
    logic [6:0]  dn;
    logic [31:0] d6;
    logic        b1;
    int          wrs;
    preload(8'h00, 32'hDF9B5713, 4);
    @(negedge clk_in);
    if_addr = 32'h1000; if_req = 1'b1;
    wrs = 0; d6 = '0; b1 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_in);
      a_seq[c] = mem_a;
      dn[c] = if_done;
      if (mem_wr) wrs++;
      if (c == 1) b1 = busy;
      if (c == 6) begin d6 = if_data; if_req = 1'b0; end
    end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (a_seq[k] !== 32'h1000 + 32'(k - 1)) begin
        bad++;
        $display("FAIL fetch_addr c%0d: got %h want %h", k, a_seq[k], 32'h1000 + 32'(k - 1));
      end
    end
    total++;
    if (a_seq[5] !== 32'h0) begin bad++; $display("FAIL fetch_addr_idle: got %h want 0", a_seq[5]); end
    total++;
    if (dn !== 7'b1000000) begin bad++; $display("FAIL fetch_done_cycle: got %b want 1000000", dn); end
    total++;
    if (d6 !== 32'hDF9B5713) begin bad++; $display("FAIL fetch_data: got %h want DF9B5713", d6); end
    total++;
    if (wrs !== 0 || b1 !== 1'b1) begin bad++; $display("FAIL fetch_wr_busy: writes=%0d busy=%b want 0,1", wrs, b1); end
    @(negedge clk_in);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fetch_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_loads();
    int lat;
    logic [31:0] rd;
    preload(8'h20, 32'h00F23480, 3);
    run_ls(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, lat, rd);
    total++;
    if (lat !== 3 || rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed: lat=%0d data=%h want 3 FFFFFF80", lat, rd); end
    run_ls(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, lat, rd);
    total++;
    if (lat !== 3 || rd !== 32'h00000080) begin bad++; $display("FAIL lb_unsigned: lat=%0d data=%h want 3 00000080", lat, rd); end
    run_ls(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, lat, rd);
    total++;
    if (lat !== 4 || rd !== 32'hFFFFF234) begin bad++; $display("FAIL lh_signed: lat=%0d data=%h want 4 FFFFF234", lat, rd); end
    run_ls(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, rd);
    total++;
    if (lat !== 4 || rd !== 32'h0000F234) begin bad++; $display("FAIL lh_unsigned: lat=%0d data=%h want 4 0000F234", lat, rd); end
  endtask

  task automatic test_stores();
    int lat;
    logic [31:0] rd;
    run_ls(1'b1, 2'b10, 1'b0, 32'h50, 32'h11223344, lat, rd);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL sw_latency: got %0d want 5", lat); end
    run_ls(1'b1, 2'b00, 1'b0, 32'h54, 32'h777777A5, lat, rd);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL sb_latency: got %0d want 2", lat); end
    run_ls(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, lat, rd);
    total++;
    if (lat !== 6 || rd !== 32'h11223344) begin bad++; $display("FAIL lw_back: lat=%0d data=%h want 6 11223344", lat, rd); end
    run_ls(1'b0, 2'b11, 1'b1, 32'h51, 32'h0, lat, rd);
    total++;
    if (lat !== 6 || rd !== 32'hA5112233) begin bad++; $display("FAIL size3_word: lat=%0d data=%h want 6 A5112233", lat, rd); end
  endtask

  task automatic test_arbitration();
    logic [31:0] wbytes, wa0, ifd;
    int nwr, ls_c, if_c;
    @(negedge clk_in);
    ls_we = 1'b1; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h40; ls_wdata = 32'hAABBCCDD;
    if_addr = 32'h1000;
    ls_req = 1'b1; if_req = 1'b1;
    wbytes = '0; wa0 = '0; ifd = '0; nwr = 0; ls_c = -1; if_c = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (mem_wr) begin
        if (nwr == 0) wa0 = mem_a;
        wbytes = {mem_dout, wbytes[31:8]};
        nwr++;
      end
      if (ls_done) begin ls_c = c; ls_req = 1'b0; end
      if (if_done) begin if_c = c; ifd = if_data; if_req = 1'b0; break; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    total++;
    if (nwr !== 4 || wbytes !== 32'hAABBCCDD || wa0 !== 32'h40) begin
      bad++;
      $display("FAIL arb_store: writes=%0d bytes=%h addr0=%h want 4 AABBCCDD 00000040", nwr, wbytes, wa0);
    end
    total++;
    if (ls_c !== 5) begin bad++; $display("FAIL arb_ls_done: cycle %0d want 5", ls_c); end
    total++;
    if (if_c !== 13 || ifd !== 32'hDF9B5713) begin bad++; $display("FAIL arb_fetch: cycle %0d data %h want 13 DF9B5713", if_c, ifd); end
  endtask

  task automatic test_io_backpressure();
    int quiet_bad, wr0, ls_c;
    logic [31:0] a6;
    logic w6;
    logic [7:0] d6;
    wr0 = wr_cnt;
    @(negedge clk_in);
    ls_we = 1'b1; ls_size = 2'b00; ls_signed = 1'b0; ls_addr = 32'h00030000; ls_wdata = 32'h0000005A;
    io_buffer_full = 1'b1; ls_req = 1'b1;
    quiet_bad = 0; ls_c = -1; a6 = '0; w6 = 1'b0; d6 = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (c >= 1 && c <= 5 && (mem_wr !== 1'b0 || mem_a !== 32'h0)) quiet_bad++;
      if (c == 5) io_buffer_full = 1'b0;
      if (c == 6) begin a6 = mem_a; w6 = mem_wr; d6 = mem_dout; end
      if (ls_done) begin ls_c = c; break; end
    end
    ls_req = 1'b0; io_buffer_full = 1'b0;
    total++;
    if (quiet_bad !== 0) begin bad++; $display("FAIL io_stall_quiet: %0d noisy cycles want 0", quiet_bad); end
    total++;
    if (a6 !== 32'h00030000 || w6 !== 1'b1 || d6 !== 8'h5A) begin
      bad++;
      $display("FAIL io_write: mem_a=%h mem_wr=%b dout=%h want 00030000 1 5A", a6, w6, d6);
    end
    total++;
    if (ls_c !== 7 || (wr_cnt - wr0) !== 1) begin bad++; $display("FAIL io_done: cycle %0d writes %0d want 7 1", ls_c, wr_cnt - wr0); end
  endtask

  task automatic test_pause();
    logic [31:0] a_seq [0:3];
    logic [31:0] rd;
    int wrs, ls_c;
    preload(8'h80, 32'hD4C3B2A1, 4);
    @(negedge clk_in);
    ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h80; ls_req = 1'b1;
    wrs = 0; ls_c = -1; rd = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_in);
      if (mem_wr) wrs++;
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c >= 6 && c <= 9) a_seq[c - 6] = mem_a;
      if (ls_done) begin ls_c = c; rd = ls_rdata; break; end
    end
    ls_req = 1'b0; rdy_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (a_seq[k] !== 32'h80 + 32'(k)) begin
        bad++;
        $display("FAIL pause_reissue c%0d: got %h want %h", k + 6, a_seq[k], 32'h80 + 32'(k));
      end
    end
    total++;
    if (ls_c !== 11 || rd !== 32'hD4C3B2A1 || wrs !== 0) begin
      bad++;
      $display("FAIL pause_result: cycle %0d data %h writes %0d want 11 D4C3B2A1 0", ls_c, rd, wrs);
    end
  endtask

  task automatic test_wrap_io();
    int lat;
    logic [31:0] rd;
    run_ls(1'b0, 2'b00, 1'b0, 32'h00030000, 32'h0, lat, rd);
    total++;
    if (lat !== 3 || rd !== 32'h0000005A) begin bad++; $display("FAIL io_byte_read: lat=%0d data=%h want 3 0000005A", lat, rd); end
    run_ls(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, lat, rd);
    total++;
    if (lat !== 3 || ram[8'hFF] !== 8'hEF || ram[8'h00] !== 8'hBE) begin
      bad++;
      $display("FAIL wrap_store: lat=%0d ram[FF]=%h ram[00]=%h want 3 EF BE", lat, ram[8'hFF], ram[8'h00]);
    end
    run_ls(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd);
    total++;
    if (lat !== 5 || rd !== 32'h0000BEEF) begin bad++; $display("FAIL wrap_io_half: lat=%0d data=%h want 5 0000BEEF", lat, rd); end
  endtask

  task automatic test_reset_mid_write();
    int wr0, late_done, lat;
    logic [31:0] rd;
    wr0 = wr_cnt;
    @(negedge clk_in);
    ls_we = 1'b1; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h60; ls_wdata = 32'h0BADF00D; ls_req = 1'b1;
    repeat (3) @(negedge clk_in);
    total++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h61 || mem_dout !== 8'hF0) begin
      bad++;
      $display("FAIL rst_pre: mem_wr=%b mem_a=%h dout=%h want 1 00000061 F0", mem_wr, mem_a, mem_dout);
    end
    #2 rst_in = 1'b1;
    #1;
    total++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0 || busy !== 1'b0 || ls_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: mem_a=%h mem_wr=%b dout=%h busy=%b ls_done=%b want all 0", mem_a, mem_wr, mem_dout, busy, ls_done);
    end
    ls_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    late_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (ls_done || busy) late_done++;
    end
    total++;
    if (late_done !== 0 || (wr_cnt - wr0) !== 1 || ram[8'h60] !== 8'h0D) begin
      bad++;
      $display("FAIL rst_abandon: done/busy cycles %0d writes %0d ram[60]=%h want 0 1 0D", late_done, wr_cnt - wr0, ram[8'h60]);
    end
    run_ls(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, lat, rd);
    total++;
    if (lat !== 3 || rd !== 32'h00000080) begin bad++; $display("FAIL rst_recover: lat=%0d data=%h want 3 00000080", lat, rd); end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_signed = 1'b0; ls_addr = '0; ls_wdata = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_arbitration();
    test_io_backpressure();
    test_pause();
    test_wrap_io();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the 8-bit synchronous memory/IO bus exported by the CPU core (mem_a, mem_wr, mem_dout, mem_din, rdy_in, io_buffer_full).
- Serialises two word-level clients into byte transactions:
  - the instruction fetch unit (32-bit reads);
  - the load/store unit (1/2/4-byte loads and stores).
- Handles the one-cycle RAM read latency, bus pauses (rdy_in low) and IO-buffer backpressure.

Parameters:
- IO_SEL_HI, 17, upper bit of the 2-bit IO-region selector.
- IO_SEL_LO, 16, lower bit; an address is IO when addr[IO_SEL_HI:IO_SEL_LO] == 2'b11.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  bus available; 0 = CPU paused, bus owned elsewhere.
- if_req  input  1  fetch request, held with if_addr stable until if_done.
- if_addr  input  32  fetch byte address.
- if_done  output  1  one-cycle pulse; if_data valid this cycle.
- if_data  output  32  fetched word, little-endian.
- ls_req  input  1  load/store request, fields held stable until ls_done.
- ls_we  input  1  1 = store.
- ls_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- ls_signed  input  1  sign-extend a load (ignored for word and for stores).
- ls_addr  input  32  byte address; no alignment requirement.
- ls_wdata  input  32  store data, low bytes first.
- ls_done  output  1  one-cycle completion pulse.
- ls_rdata  output  32  load result, zero/sign-extended; valid while ls_done=1.
- mem_din  input  8  read byte; returns the data for the address driven one rdy cycle earlier.
- mem_dout  output  8  write byte.
- mem_a  output  32  bus address.
- mem_wr  output  1  1 = write this cycle.
- io_buffer_full  input  1  IO write buffer full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- **Reset.** Async, to IDLE. All outputs are 0: mem_a=0, mem_wr=0, mem_dout=0, done pulses 0, data outputs 0, busy=0. A reset mid-transaction abandons it with no done pulse.
- **States.** IDLE, READ, WRITE, DONE. All state updates are gated by rdy_in, except the pause rule below.
- **IDLE.**
  - Bus is quiescent: mem_a=0, mem_wr=0.
  - On an edge with rdy_in=1 and a request pending, latch the request.
  - Arbitration: ls_req wins over if_req when both are high.
  - Byte count: fetch = 4; load/store = 1/2/4 from ls_size.
  - io flag is computed from the latched address.
  - Next state: READ for fetch or load, WRITE for store.
- **WRITE.**
  - Byte k goes out on mem_a = addr+k, mem_dout = byte k, mem_wr=1, one byte per cycle.
  - If io and io_buffer_full=1: drive mem_a=0, mem_wr=0 and do not advance.
  - After the last byte go to DONE.
- **READ.**
  - Issue and receive pointers are kept separately. Issue mem_a = addr+issue_idx, mem_wr=0.
  - Capture mem_din into byte recv_idx on the cycle after an issue, only if a pending flag is set. The pending flag is set by an issue made while rdy_in=1.
  - RAM addresses (io=0): pipelined. Issue byte k+1 in the same cycle byte k is captured.
  - IO addresses (io=1): never more than one outstanding read; the next byte is not issued until the previous one is captured (side-effecting reads).
  - Once all bytes are issued, drive mem_a=0.
  - After the last capture go to DONE.
- **Pause.** While rdy_in=0:
  - freeze everything and force mem_wr=0;
  - clear the pending flag;
  - rewind issue_idx to recv_idx, so the uncaptured byte is re-read after resume.
  - Writes already issued stay done.
- **DONE.**
  - Exactly one cycle. Assert if_done or ls_done for the winning client; data outputs are valid this cycle.
  - Then IDLE. The requester must drop req at the edge ending DONE; a request is never accepted during DONE.
- **Load extension.**
  - Byte: bits 31:8 = bit 7 if ls_signed, else 0.
  - Half: bits 31:16 = bit 15 if ls_signed, else 0.
- **Address arithmetic.** addr+k is 32-bit with natural wrap; halves and words may straddle any boundary.
- **Latency** (request seen at edge 0, rdy_in=1, no backpressure), done high in cycle:
  - RAM word read: 6.
  - RAM byte read: 3.
  - Word write: 5.
  - Byte write: 2.
  - IO byte read: 3.
- Data outputs hold their last value outside DONE.

Test Plan:
- **RAM word fetch.** RAM bytes 0x1000..0x1003 = 13 57 9B DF, if_req with if_addr=0x1000 -> mem_a sequence 0x1000..0x1003 in cycles 1-4; if_done in cycle 6 with if_data=0xDF9B5713.
- **Signed and unsigned byte loads.** Byte at 0x20 = 0x80; signed byte load -> ls_rdata=0xFFFFFF80; unsigned -> 0x00000080. Signed half load at 0x21 with bytes 34 F2 -> 0xFFFFF234.
- **Arbitration.** if_req and ls_req rise in the same cycle (ls is a word store of 0xAABBCCDD to 0x40) -> the store is served first: mem_wr=1 for 4 cycles with mem_dout DD,CC,BB,AA; ls_done; then the fetch runs and if_done follows.
- **IO backpressure.** Byte store to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr=0 and mem_a=0 throughout; a single write after full drops; ls_done the next cycle.
- **Pause mid-read.** Word read with rdy_in=0 for 3 cycles after byte 1 is issued -> byte 1 is re-issued after resume; the final word is correct; no mem_wr pulses occur.
- **Reset mid-write.** Async rst_in pulse during the second byte of a word store -> outputs 0 immediately, busy=0, no ls_done; a new request after reset completes normally.
